axis_ad7763_rx: RTL and testbench

- Serial receive front-end for the AD7763 24-bit ADC; sits directly upstream of the AXI-Lite stream reader and feeds its s_axis port.
- Oversamples the ADC serial port (SCO/FSO/SDO) in the aclk domain and deserialises 32-bit frames (24 data + 8 status).
- Presents each sample as a single-beat AXI4-Stream transfer with a one-entry output register, plus overrun and frame-error reporting.

---
 rtl/ad7763_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 39 +++
 rtl/axis_ad7763_rx.sv | 175 +++++++++++++++++
 tb/tb_axis_ad7763_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ad7763_pkg.sv
// Shared constants and FSM state type for the AD7763 serial receive front-end.
package ad7763_pkg;

    localparam int AD7763_DATA_BITS  = 24;
    localparam int AD7763_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous input, with a registered
// level output and registered rise/fall pulses that are all mutually aligned.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;

    // Synchroniser chain plus one extra stage so level and edges line up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= {STAGES{RST_VAL}};
            r_level <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[STAGES-2:0], i_d};
            r_level <= r_sync[STAGES-1];
            r_rise  <= r_sync[STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/axis_ad7763_rx.sv
// AD7763 serial frame receiver presenting samples as single-beat AXI4-Stream.
// Optional macro AXIS_AD7763_RX_TUSER_EN adds m_axis_tuser with the status byte.
module axis_ad7763_rx
    import ad7763_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = AD7763_DATA_BITS,
    parameter int FRAME_BITS      = AD7763_FRAME_BITS,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       adc_sco,
    input  logic                       adc_fso_n,
    input  logic                       adc_sdo,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
`ifdef AXIS_AD7763_RX_TUSER_EN
    output logic [FRAME_BITS-AXIS_DATA_WIDTH-1:0] m_axis_tuser,
`endif
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic                       frame_err
);

    localparam int STATUS_W = FRAME_BITS - AXIS_DATA_WIDTH;
    localparam int CNT_W    = $clog2(FRAME_BITS + 1);

    logic w_sco_rise;
    logic w_sco_level_unused;
    logic w_sco_fall_unused;
    logic w_fso_s;
    logic w_fso_fall;
    logic w_fso_rise_unused;
    logic w_sdo_s;
    logic w_sdo_rise_unused;
    logic w_sdo_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sco (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(adc_sco),
        .o_level(w_sco_level_unused), .o_rise(w_sco_rise), .o_fall(w_sco_fall_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_fso (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(adc_fso_n),
        .o_level(w_fso_s), .o_rise(w_fso_rise_unused), .o_fall(w_fso_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(adc_sdo),
        .o_level(w_sdo_s), .o_rise(w_sdo_rise_unused), .o_fall(w_sdo_fall_unused)
    );

    rx_state_t                     r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [FRAME_BITS-1:0]         r_shift;
    logic                          r_frame_err;
    logic [AXIS_DATA_WIDTH-1:0]    r_tdata;
    logic                          r_tvalid;
    logic                          r_overrun;
    logic                          w_load;
    logic                          w_ovr_set;

    // Frame FSM: deserialises MSB first and flags frames cut short by fso_n.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fso_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (w_fso_s) begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end else if (w_sco_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_sdo_s};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A completed frame either fills/replaces the output entry or is dropped.
    always_comb begin
        w_load    = 1'b0;
        w_ovr_set = 1'b0;
        if (r_state == DONE) begin
            if (!r_tvalid || m_axis_tready) begin
                w_load = 1'b1;
            end else begin
                w_ovr_set = 1'b1;
            end
        end else begin
            w_load    = 1'b0;
            w_ovr_set = 1'b0;
        end
    end

    // One-entry output register; tdata only changes on a load.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_tdata  <= r_shift[FRAME_BITS-1 -: AXIS_DATA_WIDTH];
                r_tvalid <= 1'b1;
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end else begin
                r_tvalid <= r_tvalid;
            end
            // A new overrun event outranks a simultaneous clear.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

`ifdef AXIS_AD7763_RX_TUSER_EN
    logic [STATUS_W-1:0] r_tuser;

    // Status byte travels alongside tdata with identical load/hold rules.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tuser <= '0;
        end else if (w_load) begin
            r_tuser <= r_shift[STATUS_W-1:0];
        end else begin
            r_tuser <= r_tuser;
        end
    end

    assign m_axis_tuser = r_tuser;
`else
    logic [STATUS_W-1:0] w_status_unused;
    assign w_status_unused = r_shift[STATUS_W-1:0];
`endif

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign overrun       = r_overrun;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_axis_ad7763_rx.sv
// Directed self-checking bench for axis_ad7763_rx; SCO runs at aclk/8.
module tb_axis_ad7763_rx;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        adc_sco;
    logic        adc_fso_n;
    logic        adc_sdo;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overrun;
    logic        overrun_clr;
    logic        frame_err;
`ifdef AXIS_AD7763_RX_TUSER_EN
    logic [7:0]  m_axis_tuser;
`endif

    int passed = 0;
    int total  = 0;

    int          beats   = 0;
    int          vcycles = 0;
    int          ferrs   = 0;
    logic [23:0] last_beat = 24'h0;

    always #5 aclk = ~aclk;

    axis_ad7763_rx dut (
        .aclk(aclk), .aresetn(aresetn),
        .adc_sco(adc_sco), .adc_fso_n(adc_fso_n), .adc_sdo(adc_sdo),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
`ifdef AXIS_AD7763_RX_TUSER_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .overrun(overrun), .overrun_clr(overrun_clr), .frame_err(frame_err)
    );

    // Handshake/pulse monitor: values seen at the clock edge itself.
    always @(posedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            beats     <= beats + 1;
            last_beat <= m_axis_tdata;
        end
        if (m_axis_tvalid) vcycles <= vcycles + 1;
        if (frame_err)     ferrs   <= ferrs + 1;
    end

    task automatic shift_bits(input logic [31:0] w, input int nbits, input bit rdy_pulse);
        logic [31:0] sh;
        sh = w;
        @(negedge aclk);
        adc_fso_n = 1'b0;
        adc_sdo   = sh[31];
        repeat (4) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            adc_sco = 1'b1;
            repeat (4) @(negedge aclk);
            adc_sco = 1'b0;
            sh      = sh << 1;
            adc_sdo = sh[31];
            if (rdy_pulse && (i == nbits - 1)) begin
                m_axis_tready = 1'b1;
                @(negedge aclk);
                m_axis_tready = 1'b0;
                repeat (3) @(negedge aclk);
            end else begin
                repeat (4) @(negedge aclk);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input bit rdy_pulse);
        shift_bits(w, nbits, rdy_pulse);
        adc_fso_n = 1'b1;
        adc_sdo   = 1'b0;
        repeat (64) @(negedge aclk);
    endtask

    task automatic drain();
        @(negedge aclk);
        m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; adc_sco = 1'b0; adc_fso_n = 1'b1; adc_sdo = 1'b0;
        m_axis_tready = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge aclk);
        total++; if (m_axis_tdata !== 24'h0) $display("FAIL reset_tdata got %h want 000000", m_axis_tdata); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passed++;
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
    endtask

    task automatic test_basic();
        int b0, v0;
        m_axis_tready = 1'b1;
        b0 = beats; v0 = vcycles;
        send_frame(32'h0000FF00, 32, 1'b0);
        total++; if (beats - b0 != 1) $display("FAIL basic_beats got %0d want 1", beats - b0); else passed++;
        total++; if (vcycles - v0 != 1) $display("FAIL basic_valid_cycles got %0d want 1", vcycles - v0); else passed++;
        total++; if (last_beat !== 24'h0000FF) $display("FAIL basic_tdata got %h want 0000ff", last_beat); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL basic_overrun got %b want 0", overrun); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL basic_tvalid_end got %b want 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_backpressure();
        int b0;
        m_axis_tready = 1'b0;
        b0 = beats;
        send_frame(32'h8000FF00, 32, 1'b0);
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL bp_tvalid got %b want 1", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 24'h8000FF) $display("FAIL bp_tdata got %h want 8000ff", m_axis_tdata); else passed++;
        repeat (20) @(negedge aclk);
        total++; if (m_axis_tdata !== 24'h8000FF || m_axis_tvalid !== 1'b1) $display("FAIL bp_hold got %h/%b want 8000ff/1", m_axis_tdata, m_axis_tvalid); else passed++;
        total++; if (beats != b0) $display("FAIL bp_no_beat got %0d want 0", beats - b0); else passed++;
        drain();
        total++; if (beats - b0 != 1) $display("FAIL bp_beat_once got %0d want 1", beats - b0); else passed++;
        total++; if (last_beat !== 24'h8000FF) $display("FAIL bp_beat_data got %h want 8000ff", last_beat); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL bp_tvalid_end got %b want 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_overrun();
        m_axis_tready = 1'b0;
        send_frame(32'h00000100, 32, 1'b0);
        send_frame(32'h00000200, 32, 1'b0);
        total++; if (m_axis_tdata !== 24'h000001) $display("FAIL ovr_tdata got %h want 000001", m_axis_tdata); else passed++;
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL ovr_tvalid got %b want 1", m_axis_tvalid); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else passed++;
        overrun_clr = 1'b1;
        @(negedge aclk);
        overrun_clr = 1'b0;
        @(negedge aclk);
        total++; if (overrun !== 1'b0) $display("FAIL ovr_clr got %b want 0", overrun); else passed++;
        total++; if (m_axis_tdata !== 24'h000001) $display("FAIL ovr_tdata_after_clr got %h want 000001", m_axis_tdata); else passed++;
    endtask

    task automatic test_accept_and_load();
        int b0;
        b0 = beats;
        send_frame(32'h00000300, 32, 1'b1);
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL sim_tvalid got %b want 1", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 24'h000003) $display("FAIL sim_tdata got %h want 000003", m_axis_tdata); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL sim_overrun got %b want 0", overrun); else passed++;
        total++; if (beats - b0 != 1) $display("FAIL sim_beats got %0d want 1", beats - b0); else passed++;
        total++; if (last_beat !== 24'h000001) $display("FAIL sim_old_beat got %h want 000001", last_beat); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        send_frame(32'h00000400, 32, 1'b0);
        total++; if (overrun !== 1'b1) $display("FAIL rmf_pre_overrun got %b want 1", overrun); else passed++;
        shift_bits(32'hFFFFFFFF, 10, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rmf_tvalid got %b want 0", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 24'h0) $display("FAIL rmf_tdata got %h want 000000", m_axis_tdata); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL rmf_overrun got %b want 0", overrun); else passed++;
        adc_fso_n = 1'b1; adc_sco = 1'b0; adc_sdo = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (70) @(negedge aclk);
        send_frame(32'h123456A5, 32, 1'b0);
        total++; if (m_axis_tdata !== 24'h123456) $display("FAIL rmf_next_tdata got %h want 123456", m_axis_tdata); else passed++;
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL rmf_next_tvalid got %b want 1", m_axis_tvalid); else passed++;
        drain();
    endtask

    task automatic test_short_frame();
        int f0, b0;
        f0 = ferrs; b0 = beats;
        m_axis_tready = 1'b1;
        send_frame(32'hABCDEF5A, 20, 1'b0);
        total++; if (ferrs - f0 != 1) $display("FAIL short_frame_err_cycles got %0d want 1", ferrs - f0); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL short_tvalid got %b want 0", m_axis_tvalid); else passed++;
        total++; if (beats != b0) $display("FAIL short_no_beat got %0d want 0", beats - b0); else passed++;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_status();
        send_frame(32'hABCDEF5A, 32, 1'b0);
        total++; if (m_axis_tdata !== 24'hABCDEF) $display("FAIL status_tdata got %h want abcdef", m_axis_tdata); else passed++;
`ifdef AXIS_AD7763_RX_TUSER_EN
        total++; if (m_axis_tuser !== 8'h5A) $display("FAIL status_tuser got %h want 5a", m_axis_tuser); else passed++;
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_accept_and_load();
        test_reset_mid_frame();
        test_short_frame();
        test_status();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
